// File: rtl/delay_timer_arbiter.sv
// -----------------------------------------------------------------------------
// delay_timer_arbiter
//
// One shared millisecond-scale delay timer for the BlackJack control FSMs.
// Each requester holds a level request together with a duration expressed in
// prescaler ticks. A round-robin arbiter hands the timer to one requester at a
// time, counts ticks, and returns a one-cycle done pulse to that requester.
// Everything runs in the clk_50M domain; the tick is an enable, not a clock.
//
// Parameters
//   N_REQ    number of requesters
//   WIDTH    duration / elapsed-count width in ticks
//   TICK_DIV clk_50M cycles per tick
//
// Ports
//   clk_50M  in   system clock
//   i_Reset  in   synchronous active-high reset
//   i_Req    in   level request per requester, held until o_Done or abandoned
//   i_Dur    in   packed durations, requester k uses [k*WIDTH +: WIDTH]
//   o_Gnt    out  one-hot owner of the timer, zero when not running
//   o_Done   out  one-cycle completion pulse to the owner
//   o_Busy   out  timer is running for an owner
//   o_Count  out  elapsed ticks of the current / most recent wait
//   o_Tick   out  one-cycle prescaler terminal pulse
// -----------------------------------------------------------------------------
module delay_timer_arbiter #(
    parameter int N_REQ    = 3,
    parameter int WIDTH    = 12,
    parameter int TICK_DIV = 25000
) (
    input  logic                     clk_50M,
    input  logic                     i_Reset,
    input  logic [N_REQ-1:0]         i_Req,
    input  logic [N_REQ*WIDTH-1:0]   i_Dur,
    output logic [N_REQ-1:0]         o_Gnt,
    output logic [N_REQ-1:0]         o_Done,
    output logic                     o_Busy,
    output logic [WIDTH-1:0]         o_Count,
    output logic                     o_Tick
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0]   dur_q, dur_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic               tick_q, tick_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;

    // Round-robin search results
    logic               found_s;
    logic [PTR_W-1:0]   pick_s;
    logic [PTR_W-1:0]   cand_s;

    // Index to one-hot requester vector
    function automatic logic [N_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
        to_onehot = N_REQ'(1) << idx;
    endfunction

    // Round-robin pick: first set request at ptr, ptr+1, ... modulo N_REQ
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        cand_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = PTR_W'((int'(ptr_q) + i) % N_REQ);
            if (!found_s && i_Req[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        dur_d   = dur_q;
        count_d = count_q;
        // Free-running prescaler; a grant overrides this with a clear
        presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);

        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    state_d = S_RUN;
                    owner_d = pick_s;
                    ptr_d   = (pick_s == PTR_LAST) ? '0 : pick_s + PTR_W'(1);
                    dur_d   = i_Dur[int'(pick_s)*WIDTH +: WIDTH];
                    count_d = '0;
                    presc_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Abandoned request wins over completion and counting
                if (!i_Req[owner_q]) begin
                    state_d = S_IDLE;
                end else if (count_q == dur_q) begin
                    state_d = S_DONE;
                end else if (tick_q) begin
                    count_d = count_q + WIDTH'(1);
                end else begin
                    count_d = count_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies
        tick_d = (presc_d == PRE_LAST);
        gnt_d  = (state_d == S_RUN)  ? to_onehot(owner_d) : '0;
        done_d = (state_d == S_DONE) ? to_onehot(owner_d) : '0;
        busy_d = (state_d == S_RUN);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            dur_q   <= '0;
            count_q <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            dur_q   <= dur_d;
            count_q <= count_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign o_Gnt   = gnt_q;
    assign o_Done  = done_q;
    assign o_Busy  = busy_q;
    assign o_Count = count_q;
    assign o_Tick  = tick_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_delay_timer_arbiter
//
// Directed bench for delay_timer_arbiter with TICK_DIV=4, WIDTH=4, N_REQ=3.
// Stimulus pushes expected grant / done / drop events (owner, cycle, count)
// into a scoreboard queue; an independent monitor detects those events on the
// DUT outputs and pops/compares them.
// -----------------------------------------------------------------------------
module tb_delay_timer_arbiter;

    localparam int N_REQ    = 3;
    localparam int WIDTH    = 4;
    localparam int TICK_DIV = 4;

    localparam int EV_GNT  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_DROP = 2;

    typedef struct {
        int kind;
        int val;
        int cyc;
        int cnt;
    } exp_t;

    logic                   clk_50M = 1'b0;
    logic                   i_Reset;
    logic [N_REQ-1:0]       i_Req;
    logic [N_REQ*WIDTH-1:0] i_Dur;
    logic [N_REQ-1:0]       o_Gnt;
    logic [N_REQ-1:0]       o_Done;
    logic                   o_Busy;
    logic [WIDTH-1:0]       o_Count;
    logic                   o_Tick;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic [N_REQ-1:0] gnt_prev = '0;

    delay_timer_arbiter #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk_50M(clk_50M),
        .i_Reset(i_Reset),
        .i_Req(i_Req),
        .i_Dur(i_Dur),
        .o_Gnt(o_Gnt),
        .o_Done(o_Done),
        .o_Busy(o_Busy),
        .o_Count(o_Count),
        .o_Tick(o_Tick)
    );

    always #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int val, input int c, input int cnt);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    task automatic handle_ev(input int kind, input int val);
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_event_kind", kind, -1);
        end else begin
            e = sb.pop_front();
            check("event_kind",  kind,         e.kind);
            check("event_owner", val,          e.val);
            check("event_cycle", cyc,          e.cyc);
            check("event_count", int'(o_Count), e.cnt);
        end
    endtask

    // Monitor: detect grant / done / drop events and compare with scoreboard
    always @(negedge clk_50M) begin
        check("gnt_onehot0",  int'($onehot0(o_Gnt)),  1);
        check("done_onehot0", int'($onehot0(o_Done)), 1);
        if (o_Done != '0)
            handle_ev(EV_DONE, int'(o_Done));
        else if (gnt_prev != '0 && o_Gnt == '0)
            handle_ev(EV_DROP, int'(gnt_prev));
        else if (gnt_prev == '0 && o_Gnt != '0)
            handle_ev(EV_GNT, int'(o_Gnt));
        gnt_prev <= o_Gnt;
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_50M);
    endtask

    task automatic set_dur(input int k, input int v);
        i_Dur[k*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int g2;
        i_Reset = 1'b1;
        i_Req   = '0;
        i_Dur   = '0;
        repeat (3) @(negedge clk_50M);
        check("rst_gnt",   int'(o_Gnt),   0);
        check("rst_done",  int'(o_Done),  0);
        check("rst_busy",  int'(o_Busy),  0);
        check("rst_count", int'(o_Count), 0);
        check("rst_tick",  int'(o_Tick),  0);
        i_Reset = 1'b0;
        @(negedge clk_50M);

        // Round-robin with all three requesting, each for one tick
        set_dur(0, 1); set_dur(1, 1); set_dur(2, 1);
        i_Req = 3'b111;
        g = cyc + 1;
        expect_ev(EV_GNT,  1, g,      0);
        expect_ev(EV_DONE, 1, g + 5,  1);
        expect_ev(EV_GNT,  2, g + 7,  0);
        expect_ev(EV_DONE, 2, g + 12, 1);
        expect_ev(EV_GNT,  4, g + 14, 0);
        expect_ev(EV_DONE, 4, g + 19, 1);
        expect_ev(EV_GNT,  1, g + 21, 0);
        expect_ev(EV_DONE, 1, g + 26, 1);
        wait_cyc(g + 26);
        i_Req = 3'b000;
        wait_cyc(g + 29);

        // Single request, duration 3: tick cadence and count progression
        set_dur(0, 3);
        i_Req = 3'b001;
        g = cyc + 1;
        expect_ev(EV_GNT,  1, g,      0);
        expect_ev(EV_DONE, 1, g + 13, 3);
        wait_cyc(g + 3);  check("tick_g3",  int'(o_Tick), 1); check("count_g3", int'(o_Count), 0);
        wait_cyc(g + 4);  check("tick_g4",  int'(o_Tick), 0); check("count_g4", int'(o_Count), 1);
        wait_cyc(g + 7);  check("tick_g7",  int'(o_Tick), 1);
        wait_cyc(g + 8);  check("count_g8", int'(o_Count), 2);
        wait_cyc(g + 11); check("tick_g11", int'(o_Tick), 1);
        wait_cyc(g + 12); check("count_g12", int'(o_Count), 3); check("busy_g12", int'(o_Busy), 1);
        wait_cyc(g + 13);
        i_Req = 3'b000;
        wait_cyc(g + 16);
        check("count_hold", int'(o_Count), 3);
        check("busy_idle",  int'(o_Busy),  0);

        // Zero duration completes without a tick
        set_dur(1, 0);
        i_Req = 3'b010;
        g = cyc + 1;
        expect_ev(EV_GNT,  2, g,     0);
        expect_ev(EV_DONE, 2, g + 1, 0);
        wait_cyc(g + 1);
        i_Req = 3'b000;
        wait_cyc(g + 3);
        check("zero_count", int'(o_Count), 0);

        // Abort by requester 2, pending requester 0 then gets a latched duration
        set_dur(2, 5);
        set_dur(0, 2);
        i_Req = 3'b100;
        g = cyc + 1;
        expect_ev(EV_GNT,  4, g,      0);
        expect_ev(EV_DROP, 4, g + 7,  1);
        expect_ev(EV_GNT,  1, g + 8,  0);
        expect_ev(EV_DONE, 1, g + 17, 2);
        wait_cyc(g + 2);
        i_Req = 3'b101;
        wait_cyc(g + 6);
        i_Req = 3'b001;
        wait_cyc(g + 7);
        check("abort_gnt",   int'(o_Gnt),   0);
        check("abort_done",  int'(o_Done),  0);
        check("abort_count", int'(o_Count), 1);
        wait_cyc(g + 8);
        set_dur(0, 9);
        wait_cyc(g + 17);
        i_Req = 3'b000;
        wait_cyc(g + 19);

        // Reset in the middle of a run, then pointer back at zero
        set_dur(1, 3);
        set_dur(2, 1);
        i_Req = 3'b010;
        g = cyc + 1;
        expect_ev(EV_GNT,  2, g,     0);
        expect_ev(EV_DROP, 2, g + 9, 0);
        wait_cyc(g + 8);
        check("pre_rst_count", int'(o_Count), 2);
        i_Reset = 1'b1;
        wait_cyc(g + 9);
        check("mid_rst_gnt",   int'(o_Gnt),   0);
        check("mid_rst_done",  int'(o_Done),  0);
        check("mid_rst_busy",  int'(o_Busy),  0);
        check("mid_rst_count", int'(o_Count), 0);
        check("mid_rst_tick",  int'(o_Tick),  0);
        i_Reset = 1'b0;
        i_Req   = 3'b110;
        g2 = cyc + 1;
        expect_ev(EV_GNT,  2, g2,      0);
        expect_ev(EV_DONE, 2, g2 + 13, 3);
        expect_ev(EV_GNT,  4, g2 + 15, 0);
        expect_ev(EV_DONE, 4, g2 + 20, 1);
        wait_cyc(g2 + 13);
        i_Req = 3'b100;
        wait_cyc(g2 + 20);
        i_Req = 3'b000;
        wait_cyc(g2 + 24);

        check("scoreboard_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
